// File: rtl/fb_alu_datapath_if.sv
// rtl/fb_alu_datapath_if.sv - sample/result bundle between a sample source and fb_alu_datapath
//
// Purpose : groups the sample stream, operand/op controls and result outputs
//           of the feedback ALU datapath into one connection.
// Signals : in, in_valid, clear, sel_1, sel_2, op   (source -> datapath)
//           out, out_valid, ovf, sticky_ovf, count  (datapath -> consumer)
// Modports: master = sample source side, slave = datapath side.
interface fb_alu_datapath_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] in;
   logic             in_valid;
   logic             clear;
   logic [1:0]       sel_1;
   logic [1:0]       sel_2;
   logic [2:0]       op;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             ovf;
   logic             sticky_ovf;
   logic [CNT_W-1:0] count;

   modport master (
      output in, in_valid, clear, sel_1, sel_2, op,
      input  out, out_valid, ovf, sticky_ovf, count
   );

   modport slave (
      input  in, in_valid, clear, sel_1, sel_2, op,
      output out, out_valid, ovf, sticky_ovf, count
   );
endinterface

// File: rtl/fb_alu_datapath.sv
// rtl/fb_alu_datapath.sv - feedback ALU datapath with history register, overflow flags and sample counter
//
// Purpose : every accepted sample is captured in reg_a while the previous
//           result moves to reg_b; a new result is computed from two selected
//           operands (reg_a / reg_b / out / zero) through an 8-op ALU.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-low reset
//           bus   - fb_alu_datapath_if.slave (sample in, controls, result out)
// Params  : WIDTH (>=4) datapath width, SAT (1 = saturating add/sub/shl),
//           CNT_W accepted-sample counter width.
module fb_alu_datapath #(
   parameter int WIDTH = 16,
   parameter int SAT   = 0,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              reset,
   fb_alu_datapath_if.slave bus
);
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] reg_a_q, reg_a_d;
   logic [WIDTH-1:0] reg_b_q, reg_b_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             ovf_q, ovf_d;
   logic             sticky_q, sticky_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [WIDTH-1:0] l_op, r_op;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic [WIDTH:0]   sum_ext, diff_ext;

   always_comb begin
      l_op = '0;
      case (bus.sel_1)
         2'b00:   l_op = reg_a_q;
         2'b01:   l_op = reg_b_q;
         2'b10:   l_op = out_q;
         default: l_op = '0;
      endcase
   end

   always_comb begin
      r_op = '0;
      case (bus.sel_2)
         2'b00:   r_op = reg_a_q;
         2'b01:   r_op = reg_b_q;
         2'b10:   r_op = out_q;
         default: r_op = '0;
      endcase
   end

   // One extra sign bit: the true signed result always fits, so overflow is
   // simply "top two bits disagree" and the top bit gives the clamp direction.
   assign sum_ext  = {l_op[WIDTH-1], l_op} + {r_op[WIDTH-1], r_op};
   assign diff_ext = {l_op[WIDTH-1], l_op} - {r_op[WIDTH-1], r_op};

   always_comb begin
      alu_res = l_op;
      alu_ovf = 1'b0;
      case (bus.op)
         3'b000: begin
            alu_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
            alu_res = sum_ext[WIDTH-1:0];
            if ((SAT != 0) && alu_ovf)
               alu_res = sum_ext[WIDTH] ? SMIN : SMAX;
         end
         3'b001: begin
            alu_ovf = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
            alu_res = diff_ext[WIDTH-1:0];
            if ((SAT != 0) && alu_ovf)
               alu_res = diff_ext[WIDTH] ? SMIN : SMAX;
         end
         3'b010: alu_res = l_op & r_op;
         3'b011: alu_res = l_op | r_op;
         3'b100: alu_res = l_op ^ r_op;
         3'b101: alu_res = l_op;
         3'b110: begin
            // Doubling overflows exactly when the sign bit would change.
            alu_ovf = l_op[WIDTH-1] ^ l_op[WIDTH-2];
            alu_res = {l_op[WIDTH-2:0], 1'b0};
            if ((SAT != 0) && alu_ovf)
               alu_res = l_op[WIDTH-1] ? SMIN : SMAX;
         end
         3'b111: alu_res = {l_op[WIDTH-1], l_op[WIDTH-1:1]};
         default: ;
      endcase
   end

   // Clear wins over a simultaneous sample, which is then dropped uncounted.
   always_comb begin
      reg_a_d     = reg_a_q;
      reg_b_d     = reg_b_q;
      out_d       = out_q;
      ovf_d       = ovf_q;
      sticky_d    = sticky_q;
      count_d     = count_q;
      out_valid_d = 1'b0;
      if (bus.clear) begin
         reg_a_d  = '0;
         reg_b_d  = '0;
         out_d    = '0;
         ovf_d    = 1'b0;
         sticky_d = 1'b0;
         count_d  = '0;
      end else if (bus.in_valid) begin
         reg_a_d     = bus.in;
         reg_b_d     = out_q;
         out_d       = alu_res;
         ovf_d       = alu_ovf;
         sticky_d    = sticky_q | alu_ovf;
         count_d     = count_q + CNT_W'(1);
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_a_q     <= '0;
         reg_b_q     <= '0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
         sticky_q    <= 1'b0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         reg_a_q     <= reg_a_d;
         reg_b_q     <= reg_b_d;
         out_q       <= out_d;
         ovf_q       <= ovf_d;
         sticky_q    <= sticky_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out        = out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.ovf        = ovf_q;
   assign bus.sticky_ovf = sticky_q;
   assign bus.count      = count_q;
endmodule

// File: tb/tb_fb_alu_datapath.sv
// tb/tb_fb_alu_datapath.sv - directed scoreboard bench for fb_alu_datapath (wrap/CNT_W=3 and saturating/CNT_W=8 instances)
module tb_fb_alu_datapath;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fb_alu_datapath_if #(.WIDTH(16), .CNT_W(3)) if0 ();
   fb_alu_datapath_if #(.WIDTH(16), .CNT_W(8)) if1 ();

   fb_alu_datapath #(.WIDTH(16), .SAT(0), .CNT_W(3)) dut0 (.clk(clk), .reset(reset), .bus(if0));
   fb_alu_datapath #(.WIDTH(16), .SAT(1), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(if1));

   typedef struct {
      logic [15:0] out [2];
      logic        ovf [2];
      logic        st  [2];
      int          cnt [2];
   } exp_t;

   exp_t sb[$];

   int n_pass = 0;
   int n_total = 0;

   logic [15:0] m_a [2];
   logic [15:0] m_b [2];
   logic [15:0] m_out [2];
   logic        m_ovf [2];
   logic        m_st [2];
   int          m_cnt [2];
   int          cmask [2] = '{7, 255};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [15:0] pick(input int d, input logic [1:0] s);
      case (s)
         2'b00:   return m_a[d];
         2'b01:   return m_b[d];
         2'b10:   return m_out[d];
         default: return 16'h0000;
      endcase
   endfunction

   // Reference ALU in plain integer arithmetic.
   task automatic alu(input logic [2:0] op, input logic [15:0] l, input logic [15:0] r,
                      input bit sat, output logic [15:0] res, output logic ov);
      int li, ri, t;
      li = int'($signed(l));
      ri = int'($signed(r));
      ov = 1'b0;
      t = 0;
      case (op)
         3'd0: t = li + ri;
         3'd1: t = li - ri;
         3'd2: t = int'(l & r);
         3'd3: t = int'(l | r);
         3'd4: t = int'(l ^ r);
         3'd5: t = li;
         3'd6: t = li * 2;
         default: t = li >>> 1;
      endcase
      if (op == 3'd0 || op == 3'd1 || op == 3'd6) begin
         ov = (t > 32767) || (t < -32768);
         if (ov && sat) t = (t > 0) ? 32767 : -32768;
      end
      res = t[15:0];
   endtask

   task automatic model_zero();
      for (int d = 0; d < 2; d++) begin
         m_a[d] = '0; m_b[d] = '0; m_out[d] = '0;
         m_ovf[d] = 1'b0; m_st[d] = 1'b0; m_cnt[d] = 0;
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_out0"}, 32'(if0.out), 32'(m_out[0]));
      chk({tag, "_out1"}, 32'(if1.out), 32'(m_out[1]));
      chk({tag, "_cnt0"}, 32'(if0.count), 32'(m_cnt[0]));
      chk({tag, "_cnt1"}, 32'(if1.count), 32'(m_cnt[1]));
      chk({tag, "_ra0"}, 32'(dut0.reg_a_q), 32'(m_a[0]));
      chk({tag, "_rb0"}, 32'(dut0.reg_b_q), 32'(m_b[0]));
      chk({tag, "_rb1"}, 32'(dut1.reg_b_q), 32'(m_b[1]));
   endtask

   // Drive one cycle (called #1 after an edge), update model, push expectation,
   // then sample #1 after the next edge and compare.
   task automatic cyc(input string tag, input logic [15:0] din, input logic vld, input logic clr,
                      input logic [1:0] s1, input logic [1:0] s2, input logic [2:0] op);
      exp_t e;
      logic [15:0] r;
      logic ov;
      bit acc;
      if0.in = din; if0.in_valid = vld; if0.clear = clr; if0.sel_1 = s1; if0.sel_2 = s2; if0.op = op;
      if1.in = din; if1.in_valid = vld; if1.clear = clr; if1.sel_1 = s1; if1.sel_2 = s2; if1.op = op;
      acc = !clr && vld;
      if (clr) model_zero();
      else if (vld) begin
         for (int d = 0; d < 2; d++) begin
            alu(op, pick(d, s1), pick(d, s2), (d == 1), r, ov);
            m_b[d] = m_out[d];
            m_a[d] = din;
            m_out[d] = r;
            m_ovf[d] = ov;
            m_st[d] = m_st[d] | ov;
            m_cnt[d] = (m_cnt[d] + 1) & cmask[d];
            e.out[d] = r; e.ovf[d] = ov; e.st[d] = m_st[d]; e.cnt[d] = m_cnt[d];
         end
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (acc) begin
         chk({tag, "_ovld0"}, 32'(if0.out_valid), 32'd1);
         chk({tag, "_ovld1"}, 32'(if1.out_valid), 32'd1);
         if (if0.out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_sb_out0"}, 32'(if0.out), 32'(e.out[0]));
            chk({tag, "_sb_out1"}, 32'(if1.out), 32'(e.out[1]));
            chk({tag, "_sb_ovf0"}, 32'(if0.ovf), 32'(e.ovf[0]));
            chk({tag, "_sb_ovf1"}, 32'(if1.ovf), 32'(e.ovf[1]));
            chk({tag, "_sb_st0"}, 32'(if0.sticky_ovf), 32'(e.st[0]));
            chk({tag, "_sb_st1"}, 32'(if1.sticky_ovf), 32'(e.st[1]));
            chk({tag, "_sb_cnt0"}, 32'(if0.count), 32'(e.cnt[0]));
            chk({tag, "_sb_cnt1"}, 32'(if1.count), 32'(e.cnt[1]));
         end
      end else begin
         chk({tag, "_ovld0_lo"}, 32'(if0.out_valid), 32'd0);
         chk({tag, "_ovld1_lo"}, 32'(if1.out_valid), 32'd0);
      end
      check_state(tag);
   endtask

   initial begin
      model_zero();
      if0.in = '0; if0.in_valid = 0; if0.clear = 0; if0.sel_1 = 0; if0.sel_2 = 0; if0.op = 0;
      if1.in = '0; if1.in_valid = 0; if1.clear = 0; if1.sel_1 = 0; if1.sel_2 = 0; if1.op = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", 32'(if1.out), 32'd0);
      chk("rst_ovld", 32'(if1.out_valid), 32'd0);
      chk("rst_cnt", 32'(if1.count), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1. Reset mid-stream, then clear with a simultaneous sample.
      for (int i = 0; i < 5; i++) cyc("pre", 16'h1234, 1, 0, 2'b00, 2'b11, 3'b101);
      chk("pre_out", 32'(if1.out), 32'h1234);
      chk("pre_cnt", 32'(if1.count), 32'd5);
      #2 reset = 1'b0;
      #1;
      model_zero();
      chk("async_out0", 32'(if0.out), 32'd0);
      chk("async_out1", 32'(if1.out), 32'd0);
      chk("async_cnt1", 32'(if1.count), 32'd0);
      chk("async_ovld", 32'(if1.out_valid), 32'd0);
      chk("async_st", 32'(if0.sticky_ovf), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      cyc("clr", 16'h0009, 1, 1, 2'b00, 2'b00, 3'b101);
      chk("clr_cnt", 32'(if1.count), 32'd0);
      chk("clr_ra", 32'(dut1.reg_a_q), 32'd0);

      // 2. Feedback add: out = reg_a + out.
      cyc("fadd1", 16'd1, 1, 0, 2'b00, 2'b10, 3'b000);
      chk("fadd1_c", 32'(if1.out), 32'd0);
      cyc("fadd2", 16'd2, 1, 0, 2'b00, 2'b10, 3'b000);
      chk("fadd2_c", 32'(if1.out), 32'd1);
      cyc("fadd3", 16'd3, 1, 0, 2'b00, 2'b10, 3'b000);
      chk("fadd3_c", 32'(if1.out), 32'd3);
      chk("fadd3_cnt", 32'(if1.count), 32'd3);

      // 3. History subtract: out = reg_a - reg_b.
      cyc("hclr", 16'd0, 0, 1, 2'b00, 2'b00, 3'b000);
      cyc("hsub1", 16'd10, 1, 0, 2'b00, 2'b01, 3'b001);
      cyc("hsub2", 16'd20, 1, 0, 2'b00, 2'b01, 3'b001);
      cyc("hsub3", 16'd30, 1, 0, 2'b00, 2'b01, 3'b001);
      chk("hsub3_c", 32'(if1.out), 32'd20);
      chk("hsub3_rb", 32'(dut1.reg_b_q), 32'd10);
      cyc("hsub4", 16'd0, 1, 0, 2'b00, 2'b01, 3'b001);

      // 4. Overflow, wrap vs saturate, sticky flag.
      cyc("oclr", 16'd0, 0, 1, 2'b00, 2'b00, 3'b000);
      cyc("ovf1", 16'h7FFF, 1, 0, 2'b00, 2'b00, 3'b000);
      cyc("ovf2", 16'h7FFF, 1, 0, 2'b00, 2'b00, 3'b000);
      chk("ovf_wrap", 32'(if0.out), 32'hFFFE);
      chk("ovf_sat", 32'(if1.out), 32'h7FFF);
      chk("ovf_flag", 32'(if0.ovf), 32'd1);
      cyc("ovf_and", 16'h8000, 1, 0, 2'b00, 2'b10, 3'b010);
      chk("ovf_and_f", 32'(if0.ovf), 32'd0);
      chk("ovf_and_st", 32'(if0.sticky_ovf), 32'd1);
      cyc("ovf_neg", 16'h8000, 1, 0, 2'b00, 2'b00, 3'b000);
      cyc("ovf_sub", 16'h0001, 1, 0, 2'b00, 2'b11, 3'b001);
      cyc("ovf_sub2", 16'h0001, 1, 0, 2'b11, 2'b10, 3'b001);

      // 5. Stall with toggling controls, then accept using the new controls.
      for (int i = 0; i < 4; i++)
         cyc("stall", 16'($urandom), 0, 0, 2'(i), 2'(3 - i), 3'(i + 2));
      cyc("post_stall", 16'h0055, 1, 0, 2'b01, 2'b00, 3'b100);
      cyc("post_stall2", 16'h00F0, 1, 0, 2'b10, 2'b00, 3'b011);

      // 6. Counter wrap on CNT_W=3 and shift ops.
      cyc("wclr", 16'd0, 0, 1, 2'b00, 2'b00, 3'b000);
      for (int i = 0; i < 9; i++) cyc("wrap", 16'(i), 1, 0, 2'b00, 2'b10, 3'b000);
      chk("wrap_cnt0", 32'(if0.count), 32'd1);
      chk("wrap_cnt1", 32'(if1.count), 32'd9);
      cyc("sh_ld", 16'hC000, 1, 0, 2'b00, 2'b00, 3'b101);
      cyc("asr", 16'h4000, 1, 0, 2'b00, 2'b00, 3'b111);
      chk("asr_out", 32'(if0.out), 32'hE000);
      chk("asr_ovf", 32'(if0.ovf), 32'd0);
      cyc("shl", 16'h0000, 1, 0, 2'b00, 2'b00, 3'b110);
      chk("shl_ovf", 32'(if0.ovf), 32'd1);
      chk("shl_wrap", 32'(if0.out), 32'h8000);
      chk("shl_sat", 32'(if1.out), 32'h7FFF);
      cyc("shl_ok", 16'h0000, 1, 0, 2'b10, 2'b00, 3'b110);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fb_alu_datapath.md
Name: fb_alu_datapath

Overview:
- Parametrised successor to the 16-bit add/sub feedback datapath.
- Each accepted sample enters an input register. The previous result moves to a history register.
- A new result is computed from two independently selected operands through an 8-operation ALU.
- Adds: valid gating, optional saturating signed arithmetic, overflow flags, synchronous clear and a sample counter. Sits between a sample source and downstream filtering/accumulation logic.

Parameters:
- WIDTH, 16, datapath width in bits (>=4).
- SAT, 0, 1 = add/sub saturate to signed min/max; 0 = two's-complement wrap.
- CNT_W, 8, width of the accepted-sample counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous active-low reset.
- in  input  WIDTH  sample data.
- in_valid  input  1  sample qualifier; when low the block stalls.
- clear  input  1  synchronous clear of all datapath state.
- sel_1  input  2  left operand select: 00 reg_a, 01 reg_b, 10 out, 11 zero.
- sel_2  input  2  right operand select, same encoding.
- op  input  3  000 add, 001 sub (L-R), 010 and, 011 or, 100 xor, 101 pass L, 110 L<<1, 111 L>>>1 (arithmetic).
- out  output  WIDTH  registered result.
- out_valid  output  1  high for one cycle after each accepted sample.
- ovf  output  1  signed overflow of the operation that produced current out.
- sticky_ovf  output  1  OR of all ovf since last reset/clear.
- count  output  CNT_W  number of accepted samples, wraps.

Behaviour:
- reset low (any time, asynchronous):
  - reg_a, reg_b, out = 0; out_valid, ovf, sticky_ovf = 0; count = 0.
  - Overrides clear and in_valid.
- Priority at each rising edge: clear > in_valid > hold.
- clear=1: same zeroing as reset, synchronous. A simultaneous in_valid sample is dropped and not counted.
- in_valid=1 (accept), all updates simultaneous (non-blocking):
  - reg_a <= in; reg_b <= out.
  - out <= f(op, L, R), where L/R are selected from pre-edge reg_a/reg_b/out.
  - ovf <= overflow of that op.
  - sticky_ovf <= sticky_ovf | ovf_new.
  - out_valid <= 1; count <= count+1 mod 2^CNT_W.
- in_valid=0: reg_a, reg_b, out, ovf, sticky_ovf, count hold; out_valid <= 0.
- Latency: a sample accepted at edge k lands in reg_a at k. It first influences out at the next accepting edge. Stall cycles between the two edges do not change this.
- Arithmetic:
  - Operands are signed WIDTH-bit.
  - add/sub computed at WIDTH+1 bits.
  - ovf=1 when the true result falls outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT=1: on overflow, out clamps to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative).
  - SAT=0: out keeps the low WIDTH bits.
- Shift and logic ops:
  - shl1: ovf=1 when L[WIDTH-1]!=L[WIDTH-2]. It saturates under SAT=1 like add.
  - asr1, and, or, xor, pass: ovf=0 always.
- sel/op are sampled only at accepting edges; changing them during stall has no effect.
- count wraps from 2^CNT_W-1 to 0, with no flag.

Test Plan:
1. Reset/clear: drive reset low mid-stream with out=0x1234, count=5 -> all outputs 0 immediately, before any clock edge. Then assert clear together with in_valid (in=0x0009) -> state stays 0, count 0.
2. Feedback add: sel_1=00, sel_2=10, op=000, in=1,2,3 on consecutive valid cycles. After edge1 out=0; edge2 out=1; edge3 out=3. count=3, out_valid high each cycle after.
3. History sub: sel_1=00, sel_2=01, op=001, in=10,20,30. After edge3: out = 20 - reg_b(=0 after edge2) = 20. Bench checks reg_b tracks previous out each accept.
4. Overflow: WIDTH=16, sel_1=sel_2=00, op=000, in=0x7FFF twice.
   - SAT=0: out=0xFFFE, ovf=1, sticky_ovf=1.
   - SAT=1: out=0x7FFF.
   - A following valid op=010 clears ovf; sticky_ovf stays 1.
5. Stall: hold in_valid low 4 cycles, toggling sel/op/in -> out, count, reg values unchanged. out_valid=0. The next accept uses the sel/op present at that edge.
6. Counter wrap: CNT_W=3, 9 accepted samples -> count=1. Shifts: in=0xC000, op=111 -> out=0xE000, ovf=0. op=110 on 0x4000 -> ovf=1.
